// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals shared by alu_arbiter and its neighbours
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  parameter int IDW = 1
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_ra;
  logic [NREQ*WIDTH-1:0] req_rb;
  logic [NREQ*5-1:0] req_op;
  logic [WIDTH-1:0] alu_ra;
  logic [WIDTH-1:0] alu_rb;
  logic alu_arith_mode;
  logic alu_logic_alt;
  logic [2:0] alu_funct3;
  logic [WIDTH-1:0] alu_arith_out;
  logic [WIDTH-1:0] alu_logic_out;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_arith;
  logic [WIDTH-1:0] rsp_logic;
  modport master (
    output req_valid, req_ra, req_rb, req_op, alu_arith_out, alu_logic_out, rsp_ready,
    input req_ready, alu_ra, alu_rb, alu_arith_mode, alu_logic_alt, alu_funct3,
    input rsp_valid, rsp_id, rsp_arith, rsp_logic
  );
  modport slave (
    input req_valid, req_ra, req_rb, req_op, alu_arith_out, alu_logic_out, rsp_ready,
    output req_ready, alu_ra, alu_rb, alu_arith_mode, alu_logic_alt, alu_funct3,
    output rsp_valid, rsp_id, rsp_arith, rsp_logic
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with registered operands and response
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, id_q, win;
  logic any;
  function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    return IDW'(j >= NREQ ? j - NREQ : j);
  endfunction
  // descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[slot(ptr, k)]) begin
        win = slot(ptr, k);
        any = 1'b1;
      end
    end
    state_nx = state == IDLE ? (any ? EXEC : IDLE) : state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
    bus.req_ready = (state == IDLE && any) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      id_q <= '0;
      bus.alu_ra <= '0;
      bus.alu_rb <= '0;
      bus.alu_arith_mode <= 1'b0;
      bus.alu_logic_alt <= 1'b0;
      bus.alu_funct3 <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_arith <= '0;
      bus.rsp_logic <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        bus.alu_ra <= bus.req_ra[win*WIDTH +: WIDTH];
        bus.alu_rb <= bus.req_rb[win*WIDTH +: WIDTH];
        {bus.alu_arith_mode, bus.alu_logic_alt, bus.alu_funct3} <= bus.req_op[win*5 +: 5];
        id_q <= win;
      end
      if (state == EXEC) begin
        bus.rsp_arith <= bus.alu_arith_out;
        bus.rsp_logic <= bus.alu_logic_out;
        bus.rsp_id <= id_q;
        bus.rsp_valid <= 1'b1;
      end
      // pointer moves only on the response handshake, past the owner of that response
      if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        ptr <= bus.rsp_id == IDW'(NREQ - 1) ? '0 : bus.rsp_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized checks of alu_arbiter (NREQ=2 and NREQ=3) against a round-robin model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic rrdy = 1'b1;
  logic [2:0] vmask = '0;
  logic [31:0] ra [3];
  logic [31:0] rb [3];
  logic [4:0] op [3];
  int total = 0;
  int bad = 0;
  int ptr = 0;
  always #5 clk = ~clk;
  alu_arbiter_if #(.WIDTH(32), .NREQ(2), .IDW(1)) if2 ();
  alu_arbiter_if #(.WIDTH(32), .NREQ(3), .IDW(2)) if3 ();
  alu_arbiter #(.WIDTH(32), .NREQ(2), .IDW(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  alu_arbiter #(.WIDTH(32), .NREQ(3), .IDW(2)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  function automatic logic [31:0] alu_a(input logic [31:0] a, input logic [31:0] b, input logic [4:0] o);
    return o[4] ? a - b : a + b;
  endfunction
  function automatic logic [31:0] alu_l(input logic [31:0] a, input logic [31:0] b, input logic [4:0] o);
    return (o[3] ? a | b : a ^ b) ^ {29'b0, o[2:0]};
  endfunction
  assign if2.req_valid = sel ? 2'b00 : vmask[1:0];
  assign if3.req_valid = sel ? vmask : 3'b000;
  assign if2.req_ra = {ra[1], ra[0]};
  assign if2.req_rb = {rb[1], rb[0]};
  assign if2.req_op = {op[1], op[0]};
  assign if3.req_ra = {ra[2], ra[1], ra[0]};
  assign if3.req_rb = {rb[2], rb[1], rb[0]};
  assign if3.req_op = {op[2], op[1], op[0]};
  assign if2.rsp_ready = rrdy;
  assign if3.rsp_ready = rrdy;
  assign if2.alu_arith_out = alu_a(if2.alu_ra, if2.alu_rb, {if2.alu_arith_mode, if2.alu_logic_alt, if2.alu_funct3});
  assign if2.alu_logic_out = alu_l(if2.alu_ra, if2.alu_rb, {if2.alu_arith_mode, if2.alu_logic_alt, if2.alu_funct3});
  assign if3.alu_arith_out = alu_a(if3.alu_ra, if3.alu_rb, {if3.alu_arith_mode, if3.alu_logic_alt, if3.alu_funct3});
  assign if3.alu_logic_out = alu_l(if3.alu_ra, if3.alu_rb, {if3.alu_arith_mode, if3.alu_logic_alt, if3.alu_funct3});
  logic [2:0] o_ready;
  logic o_rv;
  logic [1:0] o_id;
  logic [31:0] o_arith, o_logic, o_ra, o_rb;
  logic [4:0] o_op;
  assign o_ready = sel ? if3.req_ready : {1'b0, if2.req_ready};
  assign o_rv = sel ? if3.rsp_valid : if2.rsp_valid;
  assign o_id = sel ? if3.rsp_id : {1'b0, if2.rsp_id};
  assign o_arith = sel ? if3.rsp_arith : if2.rsp_arith;
  assign o_logic = sel ? if3.rsp_logic : if2.rsp_logic;
  assign o_ra = sel ? if3.alu_ra : if2.alu_ra;
  assign o_rb = sel ? if3.alu_rb : if2.alu_rb;
  assign o_op = sel ? {if3.alu_arith_mode, if3.alu_logic_alt, if3.alu_funct3}
                    : {if2.alu_arith_mode, if2.alu_logic_alt, if2.alu_funct3};
  task automatic new_op(input int i);
    ra[i] = $urandom;
    rb[i] = $urandom;
    op[i] = 5'($urandom);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    vmask = '0;
    rrdy = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ptr = 0;
  endtask
  // one transaction from an IDLE cycle; entered and left at posedge+1
  task automatic do_op(input int bp, input bit keep);
    int n, w;
    logic [31:0] e_ra, e_rb, e_ar, e_lg;
    logic [4:0] e_op;
    logic [2:0] e_rdy;
    n = sel ? 3 : 2;
    w = -1;
    for (int k = 0; k < n; k++) if (w < 0 && vmask[(ptr + k) % n]) w = (ptr + k) % n;
    e_rdy = w < 0 ? 3'b000 : 3'(1 << w);
    #1;
    total++; if (o_ready !== e_rdy) begin bad++; $display("FAIL grant got=%b exp=%b", o_ready, e_rdy); end
    if (w < 0) begin
      @(posedge clk); #1;
      total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL idle_rsp got=%b exp=0", o_rv); end
      return;
    end
    e_ra = ra[w]; e_rb = rb[w]; e_op = op[w];
    e_ar = alu_a(e_ra, e_rb, e_op); e_lg = alu_l(e_ra, e_rb, e_op);
    @(posedge clk); #1;
    total++; if (o_ready !== 3'b000) begin bad++; $display("FAIL exec_ready got=%b exp=000", o_ready); end
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL exec_rv got=%b exp=0", o_rv); end
    total++; if ({o_ra, o_rb, o_op} !== {e_ra, e_rb, e_op}) begin bad++; $display("FAIL alu_ops got=%h/%h/%h exp=%h/%h/%h", o_ra, o_rb, o_op, e_ra, e_rb, e_op); end
    new_op(w);
    if (!keep) vmask[w] = 1'b0;
    rrdy = bp == 0;
    #1;
    total++; if (o_ra !== e_ra) begin bad++; $display("FAIL alu_ra_held got=%h exp=%h", o_ra, e_ra); end
    @(posedge clk); #1;
    for (int c = 0; c <= bp; c++) begin
      total++; if ({o_rv, o_id, o_arith, o_logic} !== {1'b1, 2'(w), e_ar, e_lg})
        begin bad++; $display("FAIL rsp c=%0d got=%b/%0d/%h/%h exp=1/%0d/%h/%h", c, o_rv, o_id, o_arith, o_logic, w, e_ar, e_lg); end
      total++; if (o_ready !== 3'b000) begin bad++; $display("FAIL resp_ready got=%b exp=000", o_ready); end
      if (c < bp) @(posedge clk);
      if (c < bp) #1;
    end
    rrdy = 1'b1;
    @(posedge clk); #1;
    total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL rsp_drop got=%b exp=0", o_rv); end
    ptr = (w + 1) % n;
  endtask
  task automatic test_reset();
    #1;
    total++; if ({if2.req_ready, if2.rsp_valid, if2.rsp_id, if2.rsp_arith, if2.rsp_logic, if2.alu_ra, if2.alu_rb} !== '0)
      begin bad++; $display("FAIL reset2 got=%b/%b/%h/%h exp=0", if2.req_ready, if2.rsp_valid, if2.rsp_arith, if2.alu_ra); end
    total++; if ({if3.req_ready, if3.rsp_valid, if3.rsp_id, if3.alu_arith_mode, if3.alu_logic_alt, if3.alu_funct3} !== '0)
      begin bad++; $display("FAIL reset3 got=%b/%b/%0d exp=0", if3.req_ready, if3.rsp_valid, if3.rsp_id); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_single();
    sel = 1'b0;
    ra[0] = 32'd5; rb[0] = 32'd3; op[0] = 5'd0;
    vmask = 3'b001;
    do_op(0, 1'b0);
  endtask
  task automatic test_contention();
    rst_pulse();
    sel = 1'b0;
    vmask = 3'b011;
    repeat (6) do_op(0, 1'b1);
  endtask
  task automatic test_backpressure();
    vmask = 3'b011;
    do_op(5, 1'b1);
    do_op(5, 1'b1);
    vmask = 3'b000;
  endtask
  task automatic test_reset_mid();
    rst_pulse();
    sel = 1'b0;
    vmask = 3'b001;
    new_op(0);
    #1;
    total++; if (o_ready !== 3'b001) begin bad++; $display("FAIL mid_grant got=%b exp=001", o_ready); end
    @(posedge clk);
    #1 rst = 1'b1;
    vmask = 3'b000;
    #1;
    total++; if ({o_rv, o_id, o_arith, o_logic, o_ra, o_rb, o_op, o_ready} !== '0)
      begin bad++; $display("FAIL async_reset got=%b/%0d/%h/%h exp=0", o_rv, o_id, o_ra, o_arith); end
    @(posedge clk);
    #1 rst = 1'b0;
    ptr = 0;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL dropped_op got=%b exp=0", o_rv); end
    end
    vmask = 3'b010;
    new_op(1);
    do_op(0, 1'b0);
  endtask
  task automatic test_wrap3();
    rst_pulse();
    sel = 1'b1;
    new_op(0); new_op(2);
    vmask = 3'b100;
    do_op(1, 1'b0);
    vmask = 3'b001;
    do_op(0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      vmask = 3'($urandom_range(1, 7));
      do_op($urandom_range(0, 2), 1'($urandom));
    end
    vmask = 3'b000;
  endtask
  task automatic test_random2();
    rst_pulse();
    sel = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vmask = 3'($urandom_range(0, 3));
      do_op($urandom_range(0, 3), 1'($urandom));
    end
    vmask = 3'b000;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) new_op(i);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap3();
    test_random2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
